// File: rtl/edge_event_monitor.sv
// edge_event_monitor
// Multi-channel synchronous edge detector. Each channel can be set to detect
// rising, falling or both edges and provides a one-cycle event pulse, a sticky
// flag and a saturating event counter. irq is the registered OR of all sticky
// flags. cnt_out muxes one channel's counter out for status/debug reads.
//
// Optional build macro EDGE_MON_TIMESTAMP_EN adds a 32-bit free-running cycle
// counter and a per-channel timestamp (ts_out) captured on each counted hit.

module edge_event_monitor #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       sig_in,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH-1:0]       clr,
    input  logic [SEL_W-1:0]     cnt_sel,
    output logic [NCH-1:0]       evt,
    output logic [NCH-1:0]       sticky,
    output logic                 irq,
`ifdef EDGE_MON_TIMESTAMP_EN
    output logic [32*NCH-1:0]    ts_out,
`endif
    output logic [CNT_W-1:0]     cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [NCH-1:0]            s_q;
    logic [NCH-1:0]            p_q;
    logic [1:0]                prime_r;
    logic                      primed_s;
    logic [NCH-1:0]            hit_s;
    logic [NCH-1:0]            evt_r;
    logic [NCH-1:0]            sticky_r;
    logic                      irq_r;
    logic [NCH-1:0][CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0]          cnt_out_s;

    // Two-deep sample pipeline: s_q is the current sample, p_q the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= {NCH{1'b0}};
            p_q <= {NCH{1'b0}};
        end else begin
            s_q <= sig_in;
            p_q <= s_q;
        end
    end

    // Prime counter: p_q only holds a genuine sample two clocks after reset,
    // so detection stays masked until then to avoid edges against reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_r <= 2'd0;
        end else if (prime_r != 2'd2) begin
            prime_r <= prime_r + 2'd1;
        end else begin
            prime_r <= prime_r;
        end
    end

    assign primed_s = (prime_r == 2'd2);

    // Per-channel edge qualification against the mode currently applied.
    always_comb begin
        hit_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            hit_s[i] = primed_s &
                       ((mode[2*i]   & s_q[i] & ~p_q[i]) |
                        (mode[2*i+1] & ~s_q[i] & p_q[i]));
        end
    end

    // Event pulse register; clr never masks the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_r <= {NCH{1'b0}};
        end else begin
            evt_r <= hit_s;
        end
    end

    // Sticky flags: set on hit, clear on clr; a same-cycle hit wins over clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    sticky_r[i] <= hit_s[i];
                end else begin
                    sticky_r[i] <= sticky_r[i] | hit_s[i];
                end
            end
        end
    end

    // Saturating counters; clr with a same-cycle hit clears then counts (=1).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {NCH{CNT_ZERO}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    cnt_r[i] <= hit_s[i] ? CNT_ONE : CNT_ZERO;
                end else if (hit_s[i] && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Interrupt follows the sticky flags by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |sticky_r;
        end
    end

    // Counter read mux; out-of-range selects read as zero.
    always_comb begin
        cnt_out_s = CNT_ZERO;
        for (int i = 0; i < NCH; i++) begin
            if (int'(cnt_sel) == i) begin
                cnt_out_s = cnt_r[i];
            end else begin
                cnt_out_s = cnt_out_s;
            end
        end
    end

`ifdef EDGE_MON_TIMESTAMP_EN
    logic [31:0]          cyc_r;
    logic [NCH-1:0][31:0] ts_r;

    // Free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r <= 32'd0;
        end else begin
            cyc_r <= cyc_r + 32'd1;
        end
    end

    // Timestamp capture on hit; clr without a hit zeroes the slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_r <= {NCH{32'd0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (hit_s[i]) begin
                    ts_r[i] <= cyc_r;
                end else if (clr[i]) begin
                    ts_r[i] <= 32'd0;
                end else begin
                    ts_r[i] <= ts_r[i];
                end
            end
        end
    end

    assign ts_out = ts_r;
`endif

    assign evt     = evt_r;
    assign sticky  = sticky_r;
    assign irq     = irq_r;
    assign cnt_out = cnt_out_s;

endmodule

// File: doc/edge_event_monitor.md
Name: edge_event_monitor

Overview:
- Parametrised, multi-channel edge detector in hardware. Each channel is independently configured to detect rising, falling or both edges.
- Per channel: single-cycle event pulse, sticky flag and saturating event counter; aggregated interrupt output.
- Sits beside assertion-style checkers in our designs; gives synthesizable, counted equivalents of $rose/$fell for on-chip debug and status logic.

Parameters:
- NCH, 4, number of monitored channels (1..32)
- CNT_W, 8, per-channel event counter width (2..16)
- SEL_W, $clog2(NCH) (min 1), width of counter read-select

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- sig_in  in  NCH  monitored signals; synchronous to clk
- mode  in  2*NCH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clr  in  NCH  per-channel clear of counter and sticky flag
- cnt_sel  in  SEL_W  channel whose counter drives cnt_out
- evt  out  NCH  registered one-cycle event pulse per channel
- sticky  out  NCH  per-channel sticky event flag
- irq  out  1  OR of all sticky bits, registered
- cnt_out  out  CNT_W  counter of channel cnt_sel, combinational mux of registered counters

Behaviour:
- Reset (rst=1 at posedge): evt=0, sticky=0, irq=0, all counters=0, sample regs s_q=0 and p_q=0, prime counter=0.
- Each posedge: s_q <= sig_in; p_q <= s_q.
- Prime:
  - Detection is masked until p_q holds a real sample, i.e. until 2 posedges after rst deasserts (prime counter saturates at 2).
  - No edge is reported against reset values.
- Detect per channel i (combinational):
  - rise_i = s_q[i] & ~p_q[i]; fall_i = ~s_q[i] & p_q[i].
  - hit_i = primed & ((mode[2i]&rise_i) | (mode[2i+1]&fall_i)).
- Latency:
  - sig_in change sampled at posedge k produces evt[i]=1 for exactly one cycle after posedge k+1.
  - Counter and sticky update at the same posedge k+1; irq follows one posedge later (k+2).
- Counter: increments on hit_i; saturates at 2^CNT_W-1 with no wrap.
- Sticky: set on hit_i; cleared only by clr[i] or rst.
- clr[i] and hit_i in the same cycle (clear-then-count):
  - counter loads 1, sticky stays 1.
  - clr[i] alone: counter=0, sticky=0.
  - evt is never affected by clr.
- mode: takes effect for the detection evaluated in the same cycle. Changing mode does not retroactively generate or suppress events. mode=00 suppresses evt, counter and sticky updates; clr still works.
- Toggling every cycle in mode 11 yields evt high on consecutive cycles, one count per edge.
- cnt_sel >= NCH: cnt_out=0.
- rst asserted mid-operation: all state returns to reset values at that posedge; re-prime required after release.

Optional Feature:
- Macro: EDGE_MON_TIMESTAMP_EN
- Defined:
  - Adds 32-bit free-running cycle counter (reset to 0, wraps), output port ts_out [32*NCH].
  - Each channel latches the cycle count at the posedge its counter updates on a hit.
  - clr[i] zeroes ts_out slice i unless a hit occurs in the same cycle, in which case it latches.
- Undefined: no timestamp counter, no ts_out port, no added logic.

Test Plan:
- Prime masking: rst high 2 cycles, sig_in[0]=1 before release, mode=11. Expect no evt or count until a real edge. Then drop sig_in[0] -> evt[0] one cycle, cnt(0)=1, sticky[0]=1, irq=1 next cycle.
- Mode selectivity: ch0=01, ch1=10, ch2=11, ch3=00. Drive 3 full pulses on all channels. Expect counts 3, 3, 6, 0; sticky=0111.
- Saturation: CNT_W=4, mode=11, toggle ch1 for 40 cycles. cnt_out (cnt_sel=1) stops at 15 and never wraps; evt[1] still pulses each edge.
- Clear collision: with cnt(2)=5, assert clr[2] on the cycle hit_2 is true. Expect cnt(2)=1, sticky[2]=1. clr[2] alone next -> 0, 0; irq falls one cycle later if no other sticky.
- Reset mid-stream: cnt(0)=7, assert rst one cycle. All outputs 0. Edge on the 1st sample after release not counted; edge after priming counted as 1.
- With EDGE_MON_TIMESTAMP_EN: reset, fall edge on ch3 sampled at posedge 10 after release. ts_out[3] equals the cycle count at the posedge where cnt(3) becomes 1. Other slices remain 0.
